uart_frame_decoder: RTL and testbench
=====================================

# uart_frame_decoder

Byte-stream framer sitting directly downstream of the UART receiver. Consumes the receiver's one-cycle byte strobes and assembles fixed-length command frames (sync, opcode, payload, checksum). Validated frames go to the cracker control logic as a single-cycle command pulse with a stable opcode and payload, e.g. a target hash. Malformed or stalled frames are dropped and flagged.

## Interface
- `PAYLOAD_BYTES`, default 16: payload length in bytes (≥1); 16 carries a 128-bit target hash.
- `TIMEOUT_CLKS`, default 86800: max idle clocks between bytes inside a frame (~10 byte times at 100 MHz / 115200 baud).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `byte_valid`  in  1  one-cycle strobe from UART receiver; `byte_data` valid this cycle.
- `byte_data`  in  8  received byte.
- `cmd_valid`  out  1  one-cycle pulse: a complete, checksum-correct frame was accepted.
- `cmd_op`  out  8  opcode of last accepted frame.
- `cmd_payload`  out  8*PAYLOAD_BYTES  payload of last accepted frame; first received byte in bits [8*PAYLOAD_BYTES-1 -: 8].
- `err_checksum`  out  1  one-cycle pulse: frame dropped, checksum mismatch.
- `err_timeout`  out  1  one-cycle pulse: frame dropped, inter-byte timeout.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Frame format: `SYNC` (0xA5), opcode, PAYLOAD_BYTES payload bytes, checksum = XOR of opcode and all payload bytes.
- States:
  - IDLE: byte 0xA5 → OPCODE; any other byte is discarded silently.
  - OPCODE: next byte is stored in a shadow opcode register → PAYLOAD. Byte index is cleared.
  - PAYLOAD: each byte is shifted into the shadow payload, MSB-first. The running XOR is updated. After byte PAYLOAD_BYTES-1 → CHECK.
  - CHECK: next byte is compared with the running XOR. On match, shadow copies to `cmd_op`/`cmd_payload` and `cmd_valid` pulses. On mismatch, `err_checksum` pulses and outputs are unchanged. Either way → IDLE.
- 0xA5 has no special meaning after IDLE; inside a frame it is treated as data. There is no resync mid-frame.
- `cmd_op`/`cmd_payload` change only on commit and hold stable otherwise, including across dropped frames.
- Byte index counter width is $clog2(PAYLOAD_BYTES+1). The running XOR is 8 bits.
- All three pulses are mutually exclusive in any cycle.

## Timing
- Reset values: `cmd_valid`=0, `err_checksum`=0, `err_timeout`=0, `busy`=0, `cmd_op`=0, `cmd_payload`=0. State is IDLE, index=0, XOR=0, timeout counter=0.
- `rst` mid-frame: the frame is abandoned, no error pulse, and all of the above is restored on the next edge.
- Latency: `cmd_valid`/`err_checksum` are registered and assert in the cycle after the checksum byte's `byte_valid`. `cmd_op`/`cmd_payload` update on that same edge.
- Back-to-back `byte_valid` on consecutive cycles is accepted at full rate. A new SYNC in the cycle right after CHECK is accepted.
- Timeout: the counter clears on every `byte_valid` and increments each cycle while state ≠ IDLE. When it reaches TIMEOUT_CLKS-1 with no `byte_valid`, the next edge goes to IDLE and `err_timeout` pulses for one cycle.
- `byte_valid` in the expiry cycle wins: the byte is processed and the counter is cleared.
- `busy` is registered and tracks state.

## Configuration
- `UART_FRAME_TIMEOUT_EN` defined: the timeout counter and `err_timeout` logic are compiled in as described.
- Not defined: there is no counter, a frame waits indefinitely for its next byte, and `err_timeout` is tied to 0. The port stays present.

## Structure
- Package `uart_frame_pkg`: `SYNC_BYTE` = 8'hA5 and the `frame_state_t` enum (IDLE, OPCODE, PAYLOAD, CHECK).
- Sub-module `uart_frame_timeout`: a parameterised watchdog with inputs `clk`, `rst`, `kick`, `enable` and output `expired`. It is instantiated only under `UART_FRAME_TIMEOUT_EN`.

## Test plan
- Valid frame: A5, 01, 00..0F, 01 → `cmd_valid` 1 cycle; `cmd_op`=0x01; `cmd_payload`=0x000102…0F; no error pulses.
- Bad checksum: A5, 02, 00..0F, FF → `err_checksum` 1 cycle; `cmd_op`/`cmd_payload` keep the previous values; `busy`=0 after.
- Junk before sync: 00, 3C, A5, 01, 00..0F, 01 → junk ignored, one `cmd_valid`; `busy` rises only on A5.
- Timeout (macro on): A5, 01, 00, then no bytes for TIMEOUT_CLKS cycles → `err_timeout` 1 cycle, then IDLE. The next full valid frame gives `cmd_valid`.
- Reset mid-frame: A5, 07, 5 payload bytes, then `rst` for 1 cycle → all outputs zero, no pulses. The following valid frame is accepted.
- Full-rate stream: two valid frames with `byte_valid` high every cycle and no gaps → two `cmd_valid` pulses, the second payload matches frame 2.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared constants and frame state encoding for the UART command framer
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPCODE  = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } frame_state_t;

endpackage

// File: rtl/uart_frame_timeout.sv
// rtl/uart_frame_timeout.sv - inter-byte watchdog; expires after TIMEOUT_CLKS enabled cycles without a kick
module uart_frame_timeout #(
    parameter int TIMEOUT_CLKS = 86800
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] r_count;

    // A kick in the final cycle wins over expiry, so the byte is never lost.
    assign expired = enable && !kick && (r_count == LAST_COUNT);

    // Count idle enabled cycles; any byte, disable or expiry restarts from zero.
    always_ff @(posedge clk) begin
        if (rst || kick || !enable || expired) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - framer for SYNC/opcode/payload/XOR-checksum commands; UART_FRAME_TIMEOUT_EN adds inter-byte timeout
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 16,
    parameter int TIMEOUT_CLKS  = 86800
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       byte_valid,
    input  logic [7:0]                 byte_data,
    output logic                       cmd_valid,
    output logic [7:0]                 cmd_op,
    output logic [8*PAYLOAD_BYTES-1:0] cmd_payload,
    output logic                       err_checksum,
    output logic                       err_timeout,
    output logic                       busy
);

    localparam int PW    = 8 * PAYLOAD_BYTES;
    localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

    frame_state_t      r_state;
    frame_state_t      w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_xor;
    logic [7:0]        r_op_sh;
    logic [PW-1:0]     r_pay_sh;
    logic [7:0]        r_cmd_op;
    logic [PW-1:0]     r_cmd_payload;
    logic              r_cmd_valid;
    logic              r_err_checksum;
    logic              r_busy;
    logic              w_expired;
    logic [PW-1:0]     w_byte_ext;

    assign w_byte_ext = PW'(byte_data);

`ifdef UART_FRAME_TIMEOUT_EN
    logic r_err_timeout;

    uart_frame_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .kick   (byte_valid),
        .enable (r_state != IDLE),
        .expired(w_expired)
    );

    // Expiry only happens without a byte, so this never overlaps the other pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_expired;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_expired   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Next state: bytes advance the frame, a watchdog expiry abandons it.
    always_comb begin
        w_state_next = r_state;
        if (byte_valid) begin
            case (r_state)
                IDLE:    if (byte_data == SYNC_BYTE) w_state_next = OPCODE;
                OPCODE:  w_state_next = PAYLOAD;
                PAYLOAD: if (r_idx == LAST_IDX) w_state_next = CHECK;
                CHECK:   w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end else if (w_expired) begin
            w_state_next = IDLE;
        end
    end

    // Frame assembly into shadow registers; outputs move only on a checksum match.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_idx          <= '0;
            r_xor          <= '0;
            r_op_sh        <= '0;
            r_pay_sh       <= '0;
            r_cmd_op       <= '0;
            r_cmd_payload  <= '0;
            r_cmd_valid    <= 1'b0;
            r_err_checksum <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_busy         <= (w_state_next != IDLE);
            r_cmd_valid    <= 1'b0;
            r_err_checksum <= 1'b0;
            if (byte_valid) begin
                case (r_state)
                    OPCODE: begin
                        r_op_sh <= byte_data;
                        r_xor   <= byte_data;
                        r_idx   <= '0;
                    end
                    PAYLOAD: begin
                        r_pay_sh <= (r_pay_sh << 8) | w_byte_ext;
                        r_xor    <= r_xor ^ byte_data;
                        r_idx    <= r_idx + IDX_W'(1);
                    end
                    CHECK: begin
                        if (byte_data == r_xor) begin
                            r_cmd_op      <= r_op_sh;
                            r_cmd_payload <= r_pay_sh;
                            r_cmd_valid   <= 1'b1;
                        end else begin
                            r_err_checksum <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_valid    = r_cmd_valid;
    assign cmd_op       = r_cmd_op;
    assign cmd_payload  = r_cmd_payload;
    assign err_checksum = r_err_checksum;
    assign busy         = r_busy;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - self-checking bench for uart_frame_decoder
module tb_uart_frame_decoder;

    localparam int P  = 16;
    localparam int T  = 40;
    localparam int PW = 8 * P;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          cmd_valid;
    logic [7:0]    cmd_op;
    logic [PW-1:0] cmd_payload;
    logic          err_checksum;
    logic          err_timeout;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_cks = 0;
    int n_to = 0;

    logic [7:0]    exp_op = 8'h00;
    logic [PW-1:0] exp_pl = '0;
    logic [PW-1:0] got_pl_q[$];

    uart_frame_decoder #(
        .PAYLOAD_BYTES(P),
        .TIMEOUT_CLKS (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_payload (cmd_payload),
        .err_checksum(err_checksum),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping; values seen here are those held through the previous cycle.
    always @(posedge clk) begin
        if (cmd_valid) begin
            n_valid++;
            got_pl_q.push_back(cmd_payload);
        end
        if (err_checksum) n_cks++;
        if (err_timeout)  n_to++;
        if (cmd_valid || err_checksum || err_timeout) begin
            n_cmp++;
            if ((32'(cmd_valid) + 32'(err_checksum) + 32'(err_timeout)) > 1) begin
                n_bad++;
                $display("FAIL pulse_exclusive got v=%b c=%b t=%b required at most one", cmd_valid, err_checksum, err_timeout);
            end
        end
    end

    function automatic logic [7:0] cks_of(input logic [7:0] op, input logic [PW-1:0] pl);
        logic [7:0] c;
        c = op;
        for (int i = 0; i < P; i++) c = c ^ pl[8*i +: 8];
        return c;
    endfunction

    function automatic logic [PW-1:0] rand_payload();
        logic [PW-1:0] pl;
        for (int i = 0; i < P; i++) pl[8*i +: 8] = 8'($urandom);
        return pl;
    endfunction

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [PW-1:0] pl, input logic [7:0] cks, input int maxgap);
        drive_byte(SYNC);
        if (maxgap > 0) drive_idle(int'($urandom_range(0, maxgap)));
        drive_byte(op);
        for (int i = 0; i < P; i++) begin
            if (maxgap > 0) drive_idle(int'($urandom_range(0, maxgap)));
            drive_byte(pl[PW-1-8*i -: 8]);
        end
        if (maxgap > 0) drive_idle(int'($urandom_range(0, maxgap)));
        drive_byte(cks);
    endtask

    // stall_after = -1 stalls right after SYNC, otherwise after that payload byte index.
    task automatic send_with_stall(input logic [7:0] op, input logic [PW-1:0] pl, input int stall_after, input int stall);
        drive_byte(SYNC);
        if (stall_after < 0) drive_idle(stall);
        drive_byte(op);
        for (int i = 0; i < P; i++) begin
            drive_byte(pl[PW-1-8*i -: 8]);
            if (i == stall_after) drive_idle(stall);
        end
        drive_byte(cks_of(op, pl));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cmd_valid, err_checksum, err_timeout, busy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags got %b required 0000", {cmd_valid, err_checksum, err_timeout, busy});
        end
        n_cmp++;
        if (cmd_op !== 8'h00 || cmd_payload !== '0) begin
            n_bad++;
            $display("FAIL reset_data got op=%h pl=%h required zero", cmd_op, cmd_payload);
        end
        rst = 1'b0;
    endtask

    task automatic test_valid_frame();
        logic [PW-1:0] pl;
        int v0;
        pl = 128'h000102030405060708090A0B0C0D0E0F;
        v0 = n_valid;
        send_frame(8'h01, pl, 8'h01, 0);
        drive_idle(1);
        n_cmp++;
        if ({cmd_valid, err_checksum, err_timeout} !== 3'b100) begin
            n_bad++;
            $display("FAIL valid_pulse got v/c/t=%b required 100", {cmd_valid, err_checksum, err_timeout});
        end
        n_cmp++;
        if (cmd_op !== 8'h01 || cmd_payload !== pl) begin
            n_bad++;
            $display("FAIL valid_data got op=%h pl=%h required op=01 pl=%h", cmd_op, cmd_payload, pl);
        end
        exp_op = 8'h01;
        exp_pl = pl;
        drive_idle(2);
        n_cmp++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || n_valid - v0 != 1) begin
            n_bad++;
            $display("FAIL valid_single got v=%b busy=%b pulses=%0d required 0 0 1", cmd_valid, busy, n_valid - v0);
        end
    endtask

    task automatic test_bad_checksum();
        send_frame(8'h02, 128'h000102030405060708090A0B0C0D0E0F, 8'hFF, 0);
        drive_idle(1);
        n_cmp++;
        if ({cmd_valid, err_checksum, err_timeout} !== 3'b010) begin
            n_bad++;
            $display("FAIL badcks_pulse got v/c/t=%b required 010", {cmd_valid, err_checksum, err_timeout});
        end
        n_cmp++;
        if (cmd_op !== exp_op || cmd_payload !== exp_pl || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL badcks_hold got op=%h pl=%h busy=%b required op=%h pl=%h busy=0", cmd_op, cmd_payload, busy, exp_op, exp_pl);
        end
        drive_idle(1);
        n_cmp++;
        if (err_checksum !== 1'b0) begin
            n_bad++;
            $display("FAIL badcks_width got %b required 0", err_checksum);
        end
    endtask

    task automatic test_junk_sync();
        logic [PW-1:0] pl;
        pl = 128'h000102030405060708090A0B0C0D0E0F;
        drive_byte(8'h00);
        drive_byte(8'h3C);
        drive_byte(SYNC);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL junk_busy_low got %b required 0", busy);
        end
        drive_byte(8'h01);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL junk_busy_on_sync got %b required 1", busy);
        end
        for (int i = 0; i < P; i++) drive_byte(pl[PW-1-8*i -: 8]);
        drive_byte(8'h01);
        drive_idle(1);
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_op !== 8'h01 || cmd_payload !== pl) begin
            n_bad++;
            $display("FAIL junk_frame got v=%b op=%h pl=%h required 1 01 %h", cmd_valid, cmd_op, cmd_payload, pl);
        end
        exp_op = 8'h01;
        exp_pl = pl;
        drive_idle(2);
    endtask

    task automatic test_timeout();
        logic [PW-1:0] pl;
        logic [7:0]    op;
        int t0;
        bit early;
        pl = rand_payload();
        op = 8'($urandom);
        t0 = n_to;
`ifdef UART_FRAME_TIMEOUT_EN
        drive_byte(SYNC);
        drive_byte(8'h01);
        drive_byte(8'h00);
        early = 1'b0;
        for (int i = 1; i <= T; i++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            if (err_timeout !== 1'b0 || busy !== 1'b1) early = 1'b1;
        end
        n_cmp++;
        if (early) begin
            n_bad++;
            $display("FAIL timeout_early got early expiry or busy drop required none before %0d idle clocks", T);
        end
        @(negedge clk);
        n_cmp++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_fire got to=%b busy=%b required 1 0", err_timeout, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (err_timeout !== 1'b0 || cmd_op !== exp_op) begin
            n_bad++;
            $display("FAIL timeout_after got to=%b op=%h required 0 %h", err_timeout, cmd_op, exp_op);
        end
        send_with_stall(op, pl, -1, T - 1);
`else
        send_with_stall(op, pl, 0, 3 * T);
`endif
        drive_idle(1);
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_op !== op || cmd_payload !== pl) begin
            n_bad++;
            $display("FAIL timeout_next_frame got v=%b op=%h pl=%h required 1 %h %h", cmd_valid, cmd_op, cmd_payload, op, pl);
        end
        exp_op = op;
        exp_pl = pl;
        drive_idle(2);
        n_cmp++;
`ifdef UART_FRAME_TIMEOUT_EN
        if (n_to - t0 != 1) begin
            n_bad++;
            $display("FAIL timeout_count got %0d required 1", n_to - t0);
        end
`else
        if (n_to - t0 != 0) begin
            n_bad++;
            $display("FAIL timeout_count got %0d required 0", n_to - t0);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        logic [PW-1:0] pl;
        logic [7:0]    op;
        int v0;
        int c0;
        int t0;
        v0 = n_valid;
        c0 = n_cks;
        t0 = n_to;
        drive_byte(SYNC);
        drive_byte(8'h07);
        for (int i = 0; i < 5; i++) drive_byte(8'($urandom));
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({cmd_valid, err_checksum, err_timeout, busy} !== 4'b0000 || cmd_op !== 8'h00 || cmd_payload !== '0) begin
            n_bad++;
            $display("FAIL rst_mid got flags=%b op=%h pl=%h required all zero", {cmd_valid, err_checksum, err_timeout, busy}, cmd_op, cmd_payload);
        end
        exp_op = 8'h00;
        exp_pl = '0;
        drive_idle(2);
        n_cmp++;
        if (n_valid != v0 || n_cks != c0 || n_to != t0) begin
            n_bad++;
            $display("FAIL rst_mid_pulses got v=%0d c=%0d t=%0d new pulses required 0", n_valid - v0, n_cks - c0, n_to - t0);
        end
        pl = rand_payload();
        op = 8'($urandom);
        send_frame(op, pl, cks_of(op, pl), 0);
        drive_idle(1);
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_op !== op || cmd_payload !== pl) begin
            n_bad++;
            $display("FAIL rst_mid_next got v=%b op=%h pl=%h required 1 %h %h", cmd_valid, cmd_op, cmd_payload, op, pl);
        end
        exp_op = op;
        exp_pl = pl;
        drive_idle(2);
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] pl1;
        logic [PW-1:0] pl2;
        logic [7:0]    op1;
        logic [7:0]    op2;
        pl1 = rand_payload();
        pl2 = rand_payload();
        op1 = 8'($urandom);
        op2 = 8'($urandom);
        got_pl_q.delete();
        send_frame(op1, pl1, cks_of(op1, pl1), 0);
        send_frame(op2, pl2, cks_of(op2, pl2), 0);
        drive_idle(1);
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_op !== op2 || cmd_payload !== pl2) begin
            n_bad++;
            $display("FAIL b2b_second got v=%b op=%h pl=%h required 1 %h %h", cmd_valid, cmd_op, cmd_payload, op2, pl2);
        end
        drive_idle(2);
        n_cmp++;
        if (got_pl_q.size() != 2) begin
            n_bad++;
            $display("FAIL b2b_count got %0d pulses required 2", got_pl_q.size());
        end else begin
            n_cmp++;
            if (got_pl_q[0] !== pl1 || got_pl_q[1] !== pl2) begin
                n_bad++;
                $display("FAIL b2b_payloads got %h / %h required %h / %h", got_pl_q[0], got_pl_q[1], pl1, pl2);
            end
        end
        exp_op = op2;
        exp_pl = pl2;
    endtask

    task automatic test_random();
        logic [PW-1:0] pl;
        logic [7:0]    op;
        logic [7:0]    cks;
        logic [7:0]    junk;
        bit            bad;
        for (int it = 0; it < 24; it++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                junk = 8'($urandom);
                if (junk == SYNC) junk = 8'h5A;
                drive_byte(junk);
            end
            pl  = rand_payload();
            op  = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            cks = cks_of(op, pl);
            if (bad) cks = cks ^ 8'($urandom_range(1, 255));
            send_frame(op, pl, cks, 3);
            drive_idle(1);
            if (!bad) begin
                exp_op = op;
                exp_pl = pl;
            end
            n_cmp++;
            if (cmd_valid !== !bad || err_checksum !== bad || cmd_op !== exp_op || cmd_payload !== exp_pl) begin
                n_bad++;
                $display("FAIL random_%0d got v=%b c=%b op=%h pl=%h required v=%b c=%b op=%h pl=%h", it, cmd_valid, err_checksum, cmd_op, cmd_payload, !bad, bad, exp_op, exp_pl);
            end
            drive_idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_junk_sync();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        drive_idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
